// File: rtl/gaussian_row_filter.sv
// Streaming 3x3 Gaussian smoothing of packed RGB rows, one whole row per clock.
// Keeps the two previous rows and emits the filtered middle row one edge later.
module gaussian_row_filter #(
    parameter int COLS  = 256,
    parameter int WIDTH = 8,
    parameter int CH    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [COLS*WIDTH*CH-1:0]  row_in,
    output logic [COLS*WIDTH*CH-1:0]  row_out
);

    localparam int PW = WIDTH * CH;
    localparam int N  = COLS * PW;
    localparam int SW = WIDTH + 4;

    logic [N-1:0] prev1_q, prev1_d;
    logic [N-1:0] prev2_q, prev2_d;
    logic [N-1:0] out_q, out_d;
    logic [N-1:0] filt;
    logic [1:0]   fill_q, fill_d;

    // Kernel 1 2 1 / 2 4 2 / 1 2 1 with clamped horizontal borders.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        for (genvar k = 0; k < CH; k++) begin : g_ch
            localparam int CL = (c == 0) ? 0 : c - 1;
            localparam int CR = (c == COLS - 1) ? COLS - 1 : c + 1;
            localparam int HL = (COLS - CL) * PW - 1 - k * WIDTH;
            localparam int HC = (COLS - c)  * PW - 1 - k * WIDTH;
            localparam int HR = (COLS - CR) * PW - 1 - k * WIDTH;

            logic [SW-1:0] top_s, mid_s, bot_s, sum;

            assign top_s = SW'(prev2_q[HL -: WIDTH]) + (SW'(prev2_q[HC -: WIDTH]) << 1)
                         + SW'(prev2_q[HR -: WIDTH]);
            assign mid_s = SW'(prev1_q[HL -: WIDTH]) + (SW'(prev1_q[HC -: WIDTH]) << 1)
                         + SW'(prev1_q[HR -: WIDTH]);
            assign bot_s = SW'(row_in[HL -: WIDTH]) + (SW'(row_in[HC -: WIDTH]) << 1)
                         + SW'(row_in[HR -: WIDTH]);
            assign sum   = top_s + (mid_s << 1) + bot_s;

            assign filt[HC -: WIDTH] = WIDTH'((sum + SW'(8)) >> 4);
        end
    end

    // The first row after reset seeds both line buffers, replicating the top border.
    always_comb begin
        prev1_d = row_in;
        prev2_d = prev1_q;
        out_d   = out_q;
        fill_d  = fill_q;
        if (fill_q == 2'd0) begin
            prev2_d = row_in;
        end else begin
            out_d = filt;
        end
        if (fill_q != 2'd2) begin
            fill_d = fill_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev1_q <= '0;
            prev2_q <= '0;
            out_q   <= '0;
            fill_q  <= 2'd0;
        end else begin
            prev1_q <= prev1_d;
            prev2_q <= prev2_d;
            out_q   <= out_d;
            fill_q  <= fill_d;
        end
    end

    assign row_out = out_q;

endmodule

// File: tb/tb_gaussian_row_filter.sv
// Directed and random checks of gaussian_row_filter against an image-level Gaussian model.
module tb_gaussian_row_filter;

    localparam int COLS  = 256;
    localparam int WIDTH = 8;
    localparam int CH    = 3;
    localparam int PW    = WIDTH * CH;
    localparam int N     = COLS * PW;

    logic         clk;
    logic         rst;
    logic [N-1:0] row_in;
    logic [N-1:0] row_out;

    int vectors;
    int errs;
    logic [N-1:0] rows_q[$];

    gaussian_row_filter #(.COLS(COLS), .WIDTH(WIDTH), .CH(CH)) dut (
        .clk     (clk),
        .rst     (rst),
        .row_in  (row_in),
        .row_out (row_out)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] px(input logic [N-1:0] v, input int c, input int k);
        return v[(COLS - c) * PW - 1 - k * WIDTH -: WIDTH];
    endfunction

    function automatic logic [N-1:0] set_px(input logic [N-1:0] v, input int c, input int k,
                                            input int val);
        logic [N-1:0] r;
        r = v;
        r[(COLS - c) * PW - 1 - k * WIDTH -: WIDTH] = WIDTH'(val);
        return r;
    endfunction

    function automatic logic [N-1:0] flat_row(input int val);
        logic [N-1:0] r;
        r = '0;
        for (int c = 0; c < COLS; c++)
            for (int k = 0; k < CH; k++)
                r = set_px(r, c, k, val);
        return r;
    endfunction

    function automatic logic [N-1:0] rand_row();
        logic [N-1:0] r;
        r = '0;
        for (int c = 0; c < COLS; c++)
            for (int k = 0; k < CH; k++)
                r = set_px(r, c, k, int'($urandom_range(0, 255)));
        return r;
    endfunction

    // Weighted 3x3 neighbourhood sum over rows (top, mid, bot), columns clamped.
    function automatic logic [N-1:0] gauss(input logic [N-1:0] t, input logic [N-1:0] m,
                                           input logic [N-1:0] b);
        logic [N-1:0] r;
        int s, cc, wh;
        r = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int k = 0; k < CH; k++) begin
                s = 0;
                for (int dc = -1; dc <= 1; dc++) begin
                    cc = c + dc;
                    if (cc < 0) cc = 0;
                    if (cc > COLS - 1) cc = COLS - 1;
                    wh = (dc == 0) ? 2 : 1;
                    s += wh * (int'(px(t, cc, k)) + 2 * int'(px(m, cc, k)) + int'(px(b, cc, k)));
                end
                r = set_px(r, c, k, (s + 8) / 16);
            end
        end
        return r;
    endfunction

    // Output after accepting row n is image row n-1, with the row above clamped to row 0.
    function automatic logic [N-1:0] model_out();
        int n;
        n = rows_q.size();
        if (n < 2) return '0;
        return gauss((n >= 3) ? rows_q[n-3] : rows_q[n-2], rows_q[n-2], rows_q[n-1]);
    endfunction

    function automatic int first_diff(input logic [N-1:0] a, input logic [N-1:0] b);
        for (int c = 0; c < COLS; c++)
            for (int k = 0; k < CH; k++)
                if (px(a, c, k) !== px(b, c, k)) return c * CH + k;
        return 0;
    endfunction

    task automatic check_row(input string tag);
        logic [N-1:0] e;
        int d;
        e = model_out();
        vectors++;
        assert (row_out === e) else begin
            errs++;
            d = first_diff(row_out, e);
            $error("FAIL %s: pixel %0d ch %0d got %0d expected %0d", tag, d / CH, d % CH,
                   px(row_out, d / CH, d % CH), px(e, d / CH, d % CH));
        end
    endtask

    task automatic check_px(input string tag, input int c, input int k, input int expv);
        vectors++;
        assert (px(row_out, c, k) === WIDTH'(expv)) else begin
            errs++;
            $error("FAIL %s: pixel %0d ch %0d got %0d expected %0d", tag, c, k,
                   px(row_out, c, k), expv);
        end
    endtask

    task automatic apply(input logic [N-1:0] r, input string tag);
        row_in = r;
        @(posedge clk);
        #1;
        if (rst) rows_q.push_back(r);
        check_row(tag);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst = 1'b0;
        rows_q.delete();
        #1;
        check_row(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        vectors = 0;
        errs    = 0;
        clk     = 1'b0;
        rst     = 1'b0;
        row_in  = '0;

        // Reset held with arbitrary input, then one edge after release.
        apply(rand_row(), "reset_hold0");
        apply(rand_row(), "reset_hold1");
        @(negedge clk);
        rst = 1'b1;
        apply(rand_row(), "first_edge");

        // Flat image.
        do_reset("flat_reset");
        for (int i = 0; i < 4; i++) apply(flat_row(100), "flat");
        check_px("flat_px", 17, 1, 100);

        // Single impulse at row 2, col 100, R.
        do_reset("imp_reset");
        apply('0, "imp_r0");
        apply('0, "imp_r1");
        apply(set_px('0, 100, 0, 255), "imp_r2");
        check_px("imp_above_c", 100, 0, 32);
        check_px("imp_above_l", 99, 0, 16);
        apply('0, "imp_r3");
        check_px("imp_mid_c", 100, 0, 64);
        check_px("imp_mid_r", 101, 0, 32);
        check_px("imp_mid_g", 100, 1, 0);
        apply('0, "imp_r4");
        check_px("imp_below_c", 100, 0, 32);
        apply('0, "imp_r5");

        // Left edge clamp.
        do_reset("clamp_reset");
        r = set_px('0, 0, 0, 255);
        apply(r, "clamp_r0");
        apply(r, "clamp_r1");
        check_px("clamp_c0", 0, 0, 191);
        check_px("clamp_c1", 1, 0, 64);
        check_px("clamp_c2", 2, 0, 0);
        apply(r, "clamp_r2");

        // Top border replication.
        do_reset("top_reset");
        apply('0, "top_r0");
        apply(flat_row(160), "top_r1");
        check_px("top_px", 5, 1, 40);

        // Asynchronous reset mid-stream, then fresh history.
        do_reset("async_reset0");
        for (int i = 0; i < 10; i++) apply(flat_row(200), "stream200");
        do_reset("async_mid");
        apply(flat_row(50), "post_reset0");
        apply(flat_row(50), "post_reset1");
        check_px("post_reset_px", 200, 2, 50);

        // Random image with bottom row re-presented.
        do_reset("rand_reset");
        for (int i = 0; i < 15; i++) begin
            r = rand_row();
            apply(r, "rand");
        end
        apply(r, "rand_bottom");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
